// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator
//
// Word-level magnitude compare built by stepping a 1-bit compare cell over
// the operands MSB-first, one bit position per clock. The first differing
// bit decides the result. If no bit differs, the operands are equal.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     operand pair valid
//   in_ready     block can accept an operand pair (registered)
//   a, b         operands, WIDTH bits
//   signed_mode  1 = two's-complement compare, captured together with a/b
//   out_valid    result valid (registered)
//   out_ready    downstream accepts the result
//   smaller      A < B
//   equal        A == B
//   greater      A > B
//   bit_count    number of bit positions examined for the current/last result
//
// State table
//   state | meaning
//   IDLE  | waiting for an operand pair, in_ready=1
//   SHIFT | examining one bit position per clock, MSB first
//   DONE  | result presented, out_valid=1, waiting for out_ready

module serial_magnitude_comparator #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic                     signed_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     smaller,
    output logic                     equal,
    output logic                     greater,
    output logic [$clog2(WIDTH):0]   bit_count
);

    localparam int PW = $clog2(WIDTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             smode;
    logic [PW-1:0]    pos;

    logic msb_a;
    logic msb_b;
    logic first_pos;

    assign msb_a     = sa[WIDTH-1];
    assign msb_b     = sb[WIDTH-1];
    // Nothing has been examined yet, so the current MSB is the sign bit.
    assign first_pos = (bit_count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            smaller   <= 1'b0;
            equal     <= 1'b0;
            greater   <= 1'b0;
            bit_count <= '0;
            sa        <= '0;
            sb        <= '0;
            smode     <= 1'b0;
            pos       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sa        <= a;
                        sb        <= b;
                        smode     <= signed_mode;
                        pos       <= PW'(WIDTH - 1);
                        smaller   <= 1'b0;
                        equal     <= 1'b0;
                        greater   <= 1'b0;
                        bit_count <= '0;
                        in_ready  <= 1'b0;
                        state     <= SHIFT;
                    end
                end

                SHIFT: begin
                    bit_count <= bit_count + CW'(1);
                    if (msb_a != msb_b) begin
                        // A set sign bit means the more negative operand,
                        // so the sense flips on the first signed position.
                        if (smode && first_pos) begin
                            greater <= msb_b;
                            smaller <= msb_a;
                        end else begin
                            greater <= msb_a;
                            smaller <= msb_b;
                        end
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (pos == '0) begin
                        equal     <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        sa  <= {sa[WIDTH-2:0], 1'b0};
                        sb  <= {sb[WIDTH-2:0], 1'b0};
                        pos <= pos - PW'(1);
                    end
                end

                DONE: begin
                    // Results stay put after the handshake until the next accept.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
module tb_serial_magnitude_comparator;

    localparam int W  = 8;
    localparam int CW = $clog2(W) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          signed_mode = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          smaller;
    logic          equal;
    logic          greater;
    logic [CW-1:0] bit_count;

    int checks = 0;
    int failures = 0;

    serial_magnitude_comparator #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .signed_mode(signed_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .smaller    (smaller),
        .equal      (equal),
        .greater    (greater),
        .bit_count  (bit_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: arithmetic compare plus index of the first differing bit.
    function automatic logic [CW+2:0] ref_cmp(input logic [W-1:0] x,
                                              input logic [W-1:0] y,
                                              input logic sm);
        int first;
        int bc;
        logic s, e, g;
        first = W;
        for (int i = 0; i < W; i++)
            if (first == W && x[W-1-i] != y[W-1-i]) first = i;
        bc = (first == W) ? W : first + 1;
        if (sm) begin
            s = $signed(x) < $signed(y);
            g = $signed(x) > $signed(y);
        end else begin
            s = x < y;
            g = x > y;
        end
        e = (x == y);
        return {CW'(bc), s, e, g};
    endfunction

    // Behavioural model: phase 0 idle, 1 busy, 2 result presented.
    logic [CW+2:0] m_pred;
    logic [CW+2:0] m_res = '0;
    int            m_phase = 0;
    logic [CW-1:0] m_bc = '0;
    logic          m_s = 1'b0, m_e = 1'b0, m_g = 1'b0;

    assign m_pred = ref_cmp(a, b, signed_mode);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_bc    <= '0;
            m_s     <= 1'b0;
            m_e     <= 1'b0;
            m_g     <= 1'b0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_res   <= m_pred;
                    m_phase <= 1;
                    m_bc    <= '0;
                    m_s     <= 1'b0;
                    m_e     <= 1'b0;
                    m_g     <= 1'b0;
                end
                1: begin
                    m_bc <= m_bc + CW'(1);
                    if (m_bc + CW'(1) == m_res[CW+2:3]) begin
                        m_phase <= 2;
                        m_s     <= m_res[2];
                        m_e     <= m_res[1];
                        m_g     <= m_res[0];
                    end
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("in_ready",  int'(in_ready),  int'(m_phase == 0));
        chk("out_valid", int'(out_valid), int'(m_phase == 2));
        chk("smaller",   int'(smaller),   int'(m_s));
        chk("equal",     int'(equal),     int'(m_e));
        chk("greater",   int'(greater),   int'(m_g));
        chk("bit_count", int'(bit_count), int'(m_bc));
    end

    // All directed tasks start and end #1 after a rising edge.
    task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
        chk("pre_accept_in_ready", int'(in_ready), 1);
        a = x; b = y; signed_mode = sm; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom);
    endtask

    task automatic wait_result(input string name, input int es, input int ee,
                               input int eg, input int ebc);
        int lat;
        lat = 0;
        while (!out_valid && lat < W + 4) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_latency"},   lat, ebc);
        chk({name, "_smaller"},   int'(smaller), es);
        chk({name, "_equal"},     int'(equal), ee);
        chk({name, "_greater"},   int'(greater), eg);
        chk({name, "_bit_count"}, int'(bit_count), ebc);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_handshake_out_valid", int'(out_valid), 0);
        chk("post_handshake_in_ready", int'(in_ready), 1);
    endtask

    initial begin
        int sel;
        #12;
        chk("reset_in_ready",  int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_flags",     int'({smaller, equal, greater}), 0);
        chk("reset_bit_count", int'(bit_count), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        accept(8'hA5, 8'h25, 1'b0);  wait_result("t1", 0, 0, 1, 1); handshake();
        accept(8'h3C, 8'h3C, 1'b0);  wait_result("t2", 0, 1, 0, 8); handshake();
        accept(8'h12, 8'h13, 1'b0);  wait_result("t3", 1, 0, 0, 8); handshake();
        accept(8'hF0, 8'h05, 1'b1);  wait_result("t4s", 1, 0, 0, 1); handshake();
        accept(8'hF0, 8'h05, 1'b0);  wait_result("t4u", 0, 0, 1, 1); handshake();

        // Backpressure in DONE with a pending operand pair.
        accept(8'h80, 8'h00, 1'b0);  wait_result("t5a", 0, 0, 1, 1);
        a = 8'h12; b = 8'h13; signed_mode = 1'b0; in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("t5_hold_out_valid", int'(out_valid), 1);
            chk("t5_hold_in_ready",  int'(in_ready), 0);
            chk("t5_hold_greater",   int'(greater), 1);
            chk("t5_hold_bit_count", int'(bit_count), 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("t5_idle_in_ready",  int'(in_ready), 1);
        chk("t5_idle_out_valid", int'(out_valid), 0);
        chk("t5_idle_greater",   int'(greater), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("t5_accept_in_ready", int'(in_ready), 0);
        wait_result("t5b", 1, 0, 0, 8); handshake();

        // Reset in the middle of an equal-operand compare.
        accept(8'h77, 8'h77, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_in_ready",  int'(in_ready), 1);
        chk("t6_rst_out_valid", int'(out_valid), 0);
        chk("t6_rst_flags",     int'({smaller, equal, greater}), 0);
        chk("t6_rst_bit_count", int'(bit_count), 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            chk("t6_no_result", int'(out_valid), 0);
        end
        accept(8'h01, 8'h02, 1'b0);  wait_result("t6b", 1, 0, 0, 7); handshake();

        // Randomized traffic; the per-cycle compare process does the checking.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_valid    = 1'($urandom);
            out_ready   = 1'($urandom);
            signed_mode = 1'($urandom);
            a           = W'($urandom);
            sel         = int'($urandom_range(0, 2));
            if (sel == 0)      b = W'($urandom);
            else if (sel == 1) b = a;
            else               b = a ^ (W'(1) << $urandom_range(0, W-1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (W + 4) @(posedge clk);
        #1;
        chk("drain_in_ready", int'(in_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
